// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR (x^32 + x^22 + x^2 + x + 1) used as a pseudo-random word source.
// Loaded from seed while rst is high, then advances one step every clock.
module lfsr32 #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = 32'h8020_0003,
    parameter logic [WIDTH-1:0] ZERO_FIX = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] seed,
    output logic [0:WIDTH-1] out
);

    // Ports are ascending-indexed with index 0 as the MSB.
    // A plain assignment to a descending vector keeps that mapping: seed[0] lands on bit WIDTH-1.
    logic [WIDTH-1:0] seed_num;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic             fb;

    assign seed_num = seed;

    always_comb begin
        load_val = seed_num;
        // An all-zero state would lock up the register, so substitute ZERO_FIX.
        if (seed_num == '0) begin
            load_val = ZERO_FIX;
        end
        fb  = ^(s_q & TAPS);
        s_d = {s_q[WIDTH-2:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= load_val;
        end else begin
            s_q <= s_d;
        end
    end

    assign out = s_q;

endmodule

// File: tb/tb_lfsr32.sv
// Self-checking bench for lfsr32: a numeric reference model checked every cycle,
// plus literal expectations for the first steps after a few known seeds.
module tb_lfsr32;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk;
    logic        rst;
    logic [0:31] seed_p;
    logic [0:31] out_p;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_s;
    logic        mvalid = 1'b0;

    lfsr32 dut (
        .clk (clk),
        .rst (rst),
        .seed(seed_p),
        .out (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] to_num(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = v[i];
        return r;
    endfunction

    // Reference model: parity of the tapped bits, shifted in at the LSB.
    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic b;
        b = ($countones(s & TAPS) % 2) == 1;
        return (s * 2) | {31'd0, b};
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_s  = (to_num(seed_p) == 32'd0) ? 32'd1 : to_num(seed_p);
            mvalid = 1'b1;
        end else if (mvalid) begin
            exp_s = model_step(exp_s);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("stream", to_num(out_p), exp_s);
            total++;
            if (to_num(out_p) == 32'd0) begin
                bad++;
                $display("FAIL nonzero: got %08h expected nonzero at %0t", to_num(out_p), $time);
            end
        end
    end

    task automatic step_chk(input string name, input logic [31:0] req);
        @(posedge clk);
        #1;
        check(name, to_num(out_p), req);
    endtask

    initial begin
        logic [31:0] last;
        rst    = 1'b1;
        seed_p = 32'hAAAA_FE67;

        repeat (5) step_chk("rst_hold", 32'hAAAA_FE67);
        rst = 1'b0;
        step_chk("run1", 32'h5555_FCCE);
        step_chk("run2", 32'hAAAB_F99D);

        // Zero seed: substitute 1, then 1 -> 3 -> 6 -> D (bit 0 is a tap).
        rst    = 1'b1;
        seed_p = 32'h0;
        step_chk("zero_fix", 32'h0000_0001);
        rst = 1'b0;
        step_chk("zero_s1", 32'h0000_0003);
        step_chk("zero_s2", 32'h0000_0006);
        step_chk("zero_s3", 32'h0000_000D);
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            seed_p = $urandom;
        end

        // Mid-run single-cycle reset.
        rst    = 1'b1;
        seed_p = 32'h1234_5678;
        step_chk("mid_rst", 32'h1234_5678);
        rst    = 1'b0;
        seed_p = $urandom;
        step_chk("mid_step", 32'h2468_ACF1);

        // Seed changing every cycle while reset is held.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            seed_p = (i == 3) ? 32'd0 : $urandom;
            last   = (to_num(seed_p) == 32'd0) ? 32'd1 : to_num(seed_p);
            step_chk("rst_track", last);
        end
        rst = 1'b0;
        step_chk("track_step", model_step(last));

        // Long golden run from the reference seed.
        rst    = 1'b1;
        seed_p = 32'hAAAA_FE67;
        step_chk("gold_load", 32'hAAAA_FE67);
        rst = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            seed_p = $urandom;
        end

        // Random reset pulses and seeds, including zero seeds.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 31) == 0);
            seed_p = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
